// File: rtl/main_mem_responder_if.sv
// Single-word request/response handshake between the instruction cache and main memory.
interface main_mem_responder_if;
  logic [31:0] mem_req_addr;
  logic        mem_req_vaild;
  logic        mem_req_wr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_req_data;
  logic        mem_req_ready;

  modport master (
    output mem_req_addr,
    output mem_req_vaild,
    output mem_req_wr,
    output mem_wr_data,
    input  mem_req_data,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_addr,
    input  mem_req_vaild,
    input  mem_req_wr,
    input  mem_wr_data,
    output mem_req_data,
    output mem_req_ready
  );
endinterface

// File: rtl/main_mem_responder.sv
// Fixed-latency word memory answering cache miss/write-back requests with one ready pulse each.
// Optional read/write statistics counters are built when MEM_STATS_EN is defined.
module main_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic                clk,
  input  logic                rst,
  main_mem_responder_if.slave bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]         mem_rd_count,
  output logic [31:0]         mem_wr_count
`endif
);

  localparam int        DEPTH       = 2 ** DEPTH_LOG2;
  localparam logic [7:0] BUSY_LOAD  = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;
  localparam logic      SINGLE_CYCLE = (LATENCY == 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    RESP     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [7:0]            cnt_r;
  logic [7:0]            cnt_s;
  logic [DEPTH_LOG2-1:0] idx_r;
  logic                  wr_r;
  logic [31:0]           wdata_r;
  logic [31:0]           data_r;
  logic                  ready_r;

  logic                  accept_s;
  logic [DEPTH_LOG2-1:0] addr_idx_s;
  logic [DEPTH_LOG2-1:0] rd_idx_s;
  logic                  rd_s;
  logic                  commit_s;
  logic                  addr_unused_s;

  logic [31:0] mem [0:DEPTH-1];

  assign addr_idx_s    = bus.mem_req_addr[DEPTH_LOG2+1:2];
  assign addr_unused_s = ^{bus.mem_req_addr[1:0], bus.mem_req_addr[31:DEPTH_LOG2+2]};

  // Next-state, countdown and response-source selection.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.mem_req_vaild) begin
          accept_s = 1'b1;
          if (SINGLE_CYCLE) begin
            state_s = RESP;
          end else begin
            state_s = BUSY;
            cnt_s   = BUSY_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 8'd0) begin
          state_s = RESP;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      RESP: begin
        state_s = WAIT_LOW;
      end
      WAIT_LOW: begin
        // A valid still high after the pulse belongs to the request just answered.
        if (!bus.mem_req_vaild) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_LOW;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // With single-cycle latency RESP is entered straight from the accept edge, before the latch.
  always_comb begin
    rd_idx_s = idx_r;
    rd_s     = ~wr_r;
    if (accept_s) begin
      rd_idx_s = addr_idx_s;
      rd_s     = ~bus.mem_req_wr;
    end else begin
      rd_idx_s = idx_r;
      rd_s     = ~wr_r;
    end
  end

  // Write commit happens on the edge leaving RESP, suppressed by reset.
  always_comb begin
    commit_s = 1'b0;
    if (!rst && (state_r == RESP) && wr_r) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Control state, latched request and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      idx_r   <= '0;
      wr_r    <= 1'b0;
      wdata_r <= 32'd0;
      data_r  <= 32'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        idx_r   <= addr_idx_s;
        wr_r    <= bus.mem_req_wr;
        wdata_r <= bus.mem_wr_data;
      end
      ready_r <= (state_s == RESP);
      if ((state_s == RESP) && rd_s) begin
        data_r <= mem[rd_idx_s];
      end
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem[idx_r] <= wdata_r;
    end
  end

`ifdef MEM_STATS_EN
  // Completed-transaction counters, bumped on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_count <= 32'd0;
      mem_wr_count <= 32'd0;
    end else if (state_r == RESP) begin
      if (wr_r) begin
        mem_wr_count <= mem_wr_count + 32'd1;
      end else begin
        mem_rd_count <= mem_rd_count + 32'd1;
      end
    end
  end
`endif

  assign bus.mem_req_ready = ready_r;
  assign bus.mem_req_data  = data_r;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_main_mem_responder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  main_mem_responder_if bus4 ();
  main_mem_responder_if bus1 ();

`ifdef MEM_STATS_EN
  logic [31:0] rd4, wr4, rd1, wr1;
`endif

  main_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .bus(bus4)
`ifdef MEM_STATS_EN
    , .mem_rd_count(rd4), .mem_wr_count(wr4)
`endif
  );

  main_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef MEM_STATS_EN
    , .mem_rd_count(rd1), .mem_wr_count(wr1)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One cache-style transaction on the LATENCY=4 instance; valid is dropped on the ready edge.
  task automatic req4(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input string tag, output logic [31:0] rdata);
    int cyc;
    bit seen;
    bus4.mem_req_addr  = addr;
    bus4.mem_req_wr    = wr;
    bus4.mem_wr_data   = wdata;
    bus4.mem_req_vaild = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    rdata = 32'd0;
    while (!seen && cyc < 30) begin
      tick();
      cyc++;
      if (bus4.mem_req_ready) begin
        seen  = 1'b1;
        rdata = bus4.mem_req_data;
      end
    end
    check_val({tag, "_latency"}, 32'(cyc), 32'd4);
    bus4.mem_req_vaild = 1'b0;
    tick();
    check_val({tag, "_pulse_end"}, {31'd0, bus4.mem_req_ready}, 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    int pulses;
    int first_at;

    rst = 1'b1;
    bus4.mem_req_addr = 32'd0; bus4.mem_req_wr = 1'b0; bus4.mem_wr_data = 32'd0; bus4.mem_req_vaild = 1'b0;
    bus1.mem_req_addr = 32'd0; bus1.mem_req_wr = 1'b0; bus1.mem_wr_data = 32'd0; bus1.mem_req_vaild = 1'b0;
    dut.mem[5]  = 32'hDEADBEEF;
    dut.mem[7]  = 32'h11111111;
    dut1.mem[3] = 32'hCAFEF00D;
    tick();
    tick();
    rst = 1'b0;
    check_val("reset_ready", {31'd0, bus4.mem_req_ready}, 32'd0);
    check_val("reset_data", bus4.mem_req_data, 32'd0);
    check_val("reset_ready_l1", {31'd0, bus1.mem_req_ready}, 32'd0);

    // Read latency and data hold
    req4(32'h14, 1'b0, 32'd0, "rd14", rd);
    check_val("rd14_data", rd, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) tick();
    check_val("rd14_hold", bus4.mem_req_data, 32'hDEADBEEF);

    // Write then read same word; write leaves read data untouched
    req4(32'h20, 1'b1, 32'h12345678, "wr20", rd);
    check_val("wr20_data_held", bus4.mem_req_data, 32'hDEADBEEF);
    req4(32'h20, 1'b0, 32'd0, "rd20", rd);
    check_val("rd20_data", rd, 32'h12345678);

    // Address wrap and byte-offset ignore
    req4(32'h0000_1003, 1'b1, 32'hAABBCCDD, "wr1003", rd);
    req4(32'h0000_0000, 1'b0, 32'd0, "rd0", rd);
    check_val("wrap_data", rd, 32'hAABBCCDD);

    // Stale valid: held high for well past the pulse yields a single ready
    bus4.mem_req_addr = 32'h14; bus4.mem_req_wr = 1'b0; bus4.mem_req_vaild = 1'b1;
    pulses = 0;
    first_at = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus4.mem_req_ready) begin
        pulses++;
        if (first_at == 0) first_at = c;
      end
    end
    check_val("stale_pulses", 32'(pulses), 32'd1);
    check_val("stale_first", 32'(first_at), 32'd4);
    bus4.mem_req_vaild = 1'b0;
    tick();
    req4(32'h20, 1'b0, 32'd0, "stale_rerq", rd);
    check_val("stale_rerq_data", rd, 32'h12345678);

    // Valid dropped and address changed mid-BUSY: latched request completes
    bus4.mem_req_addr = 32'h14; bus4.mem_req_wr = 1'b0; bus4.mem_req_vaild = 1'b1;
    tick();
    bus4.mem_req_vaild = 1'b0;
    bus4.mem_req_addr  = 32'h20;
    pulses = 0;
    first_at = 0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (bus4.mem_req_ready) begin
        pulses++;
        if (first_at == 0) first_at = c;
        check_val("drop_data", bus4.mem_req_data, 32'hDEADBEEF);
      end
    end
    check_val("drop_pulses", 32'(pulses), 32'd1);
    check_val("drop_first", 32'(first_at), 32'd4);

    // LATENCY=1 instance
    bus1.mem_req_addr = 32'hC; bus1.mem_req_wr = 1'b0; bus1.mem_req_vaild = 1'b1;
    tick();
    check_val("l1_ready", {31'd0, bus1.mem_req_ready}, 32'd1);
    check_val("l1_data", bus1.mem_req_data, 32'hCAFEF00D);
    bus1.mem_req_vaild = 1'b0;
    tick();
    check_val("l1_ready_low", {31'd0, bus1.mem_req_ready}, 32'd0);

    // Reset during RESP of a write: not committed, outputs cleared
    bus4.mem_req_addr = 32'h1C; bus4.mem_req_wr = 1'b1; bus4.mem_wr_data = 32'h33333333; bus4.mem_req_vaild = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    check_val("rstresp_ready", {31'd0, bus4.mem_req_ready}, 32'd1);
    rst = 1'b1;
    bus4.mem_req_vaild = 1'b0;
    tick();
    rst = 1'b0;
    check_val("rstresp_ready_after", {31'd0, bus4.mem_req_ready}, 32'd0);
    check_val("rstresp_data_after", bus4.mem_req_data, 32'd0);
    check_val("rstresp_mem", dut.mem[7], 32'h11111111);

    // Reset during BUSY: request discarded, no ready at all
    req4(32'h14, 1'b0, 32'd0, "pre_busy", rd);
    bus4.mem_req_addr = 32'h1C; bus4.mem_req_wr = 1'b1; bus4.mem_wr_data = 32'h44444444; bus4.mem_req_vaild = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    bus4.mem_req_vaild = 1'b0;
    tick();
    rst = 1'b0;
    check_val("rstbusy_ready_after", {31'd0, bus4.mem_req_ready}, 32'd0);
    check_val("rstbusy_data_after", bus4.mem_req_data, 32'd0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus4.mem_req_ready) pulses++;
    end
    check_val("rstbusy_pulses", 32'(pulses), 32'd0);
    check_val("rstbusy_mem", dut.mem[7], 32'h11111111);

    req4(32'h1C, 1'b0, 32'd0, "post_rst", rd);
    check_val("post_rst_data", rd, 32'h11111111);

`ifdef MEM_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("stats_rd_reset", rd4, 32'd0);
    check_val("stats_wr_reset", wr4, 32'd0);
    req4(32'h14, 1'b0, 32'd0, "st_r1", rd);
    req4(32'h40, 1'b1, 32'h01020304, "st_w1", rd);
    req4(32'h40, 1'b0, 32'd0, "st_r2", rd);
    check_val("st_r2_data", rd, 32'h01020304);
    req4(32'h44, 1'b1, 32'h05060708, "st_w2", rd);
    req4(32'h44, 1'b0, 32'd0, "st_r3", rd);
    check_val("stats_rd", rd4, 32'd3);
    check_val("stats_wr", wr4, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("stats_rd_clr", rd4, 32'd0);
    check_val("stats_wr_clr", wr4, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Main-memory responder for the instruction-cache memory port. It accepts single-word read and write requests that the cache issues on its `mem_req_*` handshake and services them from an internal word array after a fixed, parameterised latency. For each request it returns exactly one `mem_req_ready` pulse, with read data alongside. It sits between the cache miss/write-back path and the rest of the memory system, and is also the bench memory model for cache verification.

## Interface
- `DEPTH_LOG2`, default 10: the array holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 4, legal range 1..255: the number of cycles from the request being seen to `mem_req_ready` going high.
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `mem_req_addr`  input  32  byte address. Word index = `mem_req_addr[DEPTH_LOG2+1:2]`. Bits [1:0] and the bits above the index are ignored, so the address wraps modulo the array size.
- `mem_req_vaild`  input  1  request valid; the spelling matches the cache port. The cache holds it, together with addr/wr/wdata, until it sees ready.
- `mem_req_wr`  input  1  1 = write, 0 = read.
- `mem_wr_data`  input  32  write data.
- `mem_req_data`  output  32  read data. It is valid in the ready cycle and held until the next read response.
- `mem_req_ready`  output  1  one-cycle completion pulse.
- `mem_rd_count`, `mem_wr_count`  output  32 each  present only with `MEM_STATS_EN`.

## Operation
- FSM states: `IDLE`, `BUSY`, `RESP`, `WAIT_LOW`. Reset state is `IDLE`.
- **IDLE:** if `mem_req_vaild`=1, latch the word index, `wr` and `wdata` (the accept edge).
  - If `LATENCY`=1, go to `RESP`.
  - Otherwise go to `BUSY`, with the 8-bit counter loaded to `LATENCY`-2.
- **BUSY:** if the counter is 0, go to `RESP`; otherwise decrement. Inputs are not re-sampled, so later changes to addr/wdata are ignored.
- **Entering RESP:**
  - For a read, `mem_req_data` <= `mem[idx]`.
  - For a write, `mem_req_data` is unchanged.
- **RESP:** `mem_req_ready`=1 for exactly this cycle.
  - For a write, `mem[idx]` <= latched wdata on the edge that leaves `RESP`.
  - Always go to `WAIT_LOW`.
- **WAIT_LOW:** go to `IDLE` when `mem_req_vaild`=0. No request is accepted in this state, so a stale valid that is still high just after the pulse is never taken as a second request.
- Ordering: a read that follows a write to the same word returns the new data. The write commits before any later request can reach `RESP`.
- Protocol violation: if valid drops while the FSM is in `BUSY`, the latched request still completes and ready still pulses.
- Array contents are not initialised or cleared by reset. The bench preloads them hierarchically.

## Timing
- Cycle 0 is the first `IDLE` cycle with valid=1. `mem_req_ready` is high in cycle `LATENCY` and low in every other cycle.
- With the cache's behaviour (valid dropped on the edge where it samples ready), the earliest next accept is cycle `LATENCY`+2.
- Reset values: `mem_req_ready`=0, `mem_req_data`=0, and the counters (when present) = 0.
- Reset takes priority in every state:
  - A pending request is discarded and no ready is issued.
  - A write whose `RESP` cycle coincides with `rst`=1 is not committed.
  - The FSM returns to `IDLE`.

## Configuration
- `MEM_STATS_EN` defined:
  - Adds the `mem_rd_count` and `mem_wr_count` ports.
  - Each counter increments by 1 on the edge that leaves `RESP`, for reads or writes respectively.
  - The counters wrap at 2^32 and clear on `rst`.
- `MEM_STATS_EN` undefined: the ports and the counter logic are absent. All other behaviour is identical.

## Test plan
- Read latency: preload `mem[5]`=32'hDEADBEEF, `LATENCY`=4. Hold valid with addr 32'h14 and wr=0 from cycle 0 -> ready is high only in cycle 4, with data 32'hDEADBEEF. Data is still 32'hDEADBEEF 10 cycles later.
- Write then read: write 32'h12345678 to addr 32'h20, drop valid on the ready edge, then read 32'h20 -> the read returns 32'h12345678. The second accept happens no earlier than cycle 6 (`LATENCY`=4).
- Wrap and alignment: `DEPTH_LOG2`=10. A write to 32'h0000_1003 followed by a read of 32'h0000_0000 -> the read returns the written value.
- Stale valid: keep valid high for 3 cycles after the ready pulse -> no second ready until valid has been seen low and then high again.
- `LATENCY`=1: ready is high in cycle 1 after the request is first seen. Separately, assert `rst` during `BUSY` and during the `RESP` of a write -> no ready pulse, the memory word is unchanged, and outputs are 0 the next cycle.
- With `MEM_STATS_EN`: 3 reads and 2 writes -> `mem_rd_count`=3 and `mem_wr_count`=2. After `rst`, both counters are 0.
